// File: rtl/a_if_pkg.sv
// a_if_pkg: shared widths, width rules and FSM states for the a_port_driver slice
package a_if_pkg;
  localparam int G_W1_DEF = 8;
  localparam int G_W2_DEF = 4;
  localparam int G_W3_DEF = 3;
  localparam int DELAY_DEF = 5;
  typedef enum logic {IDLE, WAIT} state_t;
  function automatic int w_d1(input int g);
    return g;
  endfunction
  function automatic int w_d2(input int g);
    return g + 2;
  endfunction
  function automatic int w_d3(input int g);
    return g * 2;
  endfunction
  function automatic int cnt_w(input int d);
    return (d < 1) ? 1 : $clog2(d + 1);
  endfunction
endpackage

// File: rtl/a_port_driver_if.sv
// a_port_driver_if: upstream handshake plus d1/d2/d3 port bundle
interface a_port_driver_if
  import a_if_pkg::*;
#(
  parameter int g_w1 = G_W1_DEF,
  parameter int g_w2 = G_W2_DEF,
  parameter int g_w3 = G_W3_DEF
) ();
  logic in_valid;
  logic in_ready;
  logic [w_d1(g_w1)-1:0] in_d1;
  logic [w_d2(g_w2)-1:0] in_d2;
  logic [w_d3(g_w3)-1:0] in_d3;
  logic [w_d1(g_w1)-1:0] d1;
  logic [w_d2(g_w2)-1:0] d2;
  logic [w_d3(g_w3)-1:0] d3;
  logic d_strobe;
  logic busy;
  modport master (output in_valid, in_d1, in_d2, in_d3, input in_ready, d1, d2, d3, d_strobe, busy);
  modport slave (input in_valid, in_d1, in_d2, in_d3, output in_ready, d1, d2, d3, d_strobe, busy);
endinterface

// File: rtl/a_delay_counter.sv
// a_delay_counter: loadable down-counter that saturates at zero
module a_delay_counter
  import a_if_pkg::*;
#(
  parameter int delay = DELAY_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [cnt_w(delay)-1:0]   load_val,
  output logic                      zero
);
  logic [cnt_w(delay)-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (!zero) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/a_port_driver.sv
// a_port_driver: presents each accepted word on d1/d2/d3 delay+1 clocks after acceptance
module a_port_driver
  import a_if_pkg::*;
#(
  parameter int g_w1 = G_W1_DEF,
  parameter int g_w2 = G_W2_DEF,
  parameter int g_w3 = G_W3_DEF,
  parameter int delay = DELAY_DEF
) (
  input logic            clk,
  input logic            rst_n,
  a_port_driver_if.slave p
);
  localparam int CW = cnt_w(delay);
  state_t state, state_nx;
  logic [w_d1(g_w1)-1:0] q1;
  logic [w_d2(g_w2)-1:0] q2;
  logic [w_d3(g_w3)-1:0] q3;
  logic zero, rdy, xfer, fire;
  always_comb begin
    rdy = rst_n && (state == IDLE || zero);
    xfer = p.in_valid && rdy;
    fire = state == WAIT && zero;
    state_nx = xfer ? WAIT : fire ? IDLE : state;
  end
  assign p.in_ready = rdy;
  assign p.busy = state == WAIT;
  a_delay_counter #(.delay(delay)) u_cnt (
    .clk(clk),
    .rst_n(rst_n),
    .load(xfer),
    .load_val(CW'(delay)),
    .zero(zero)
  );
  // presentation and a new acceptance can share an edge: outputs take the old pending word
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      q1 <= '0;
      q2 <= '0;
      q3 <= '0;
      p.d1 <= '0;
      p.d2 <= '0;
      p.d3 <= '0;
      p.d_strobe <= 1'b0;
    end else begin
      state <= state_nx;
      p.d_strobe <= fire;
      if (xfer) begin
        q1 <= p.in_d1;
        q2 <= p.in_d2;
        q3 <= p.in_d3;
      end
      if (fire) begin
        p.d1 <= q1;
        p.d2 <= q2;
        p.d3 <= q3;
      end
    end
endmodule

// File: tb/tb_a_port_driver.sv
// tb_a_port_driver: three configurations checked every cycle against a timestamp model
module tb_a_port_driver;
  import a_if_pkg::*;
  logic clk = 1'b0;
  logic rst_n, in_valid;
  logic [31:0] pay1, pay2, pay3;
  int n_run = 0, n_fail = 0;
  always #5 clk = ~clk;
  task automatic chk(input int c, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL cfg%0d %s at %0t: got %0h expected %0h", c, nm, $time, act, exp);
    end
  endtask
  for (genvar k = 0; k < 3; k++) begin : g
    localparam int W1 = k == 2 ? 3 : 8;
    localparam int GW2 = k == 2 ? 0 : 4;
    localparam int GW3 = k == 2 ? 1 : 3;
    localparam int D = k == 0 ? 5 : k == 1 ? 0 : 2;
    localparam int W2 = w_d2(GW2);
    localparam int W3 = w_d3(GW3);
    a_port_driver_if #(.g_w1(W1), .g_w2(GW2), .g_w3(GW3)) bus ();
    a_port_driver #(.g_w1(W1), .g_w2(GW2), .g_w3(GW3), .delay(D)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .p(bus)
    );
    assign bus.in_valid = in_valid;
    assign bus.in_d1 = pay1[W1-1:0];
    assign bus.in_d2 = pay2[W2-1:0];
    assign bus.in_d3 = pay3[W3-1:0];
    // model: a word accepted at edge t is shown at edge t+D+1; age counts edges since acceptance
    bit pend;
    int age;
    logic [W1-1:0] q1, e1;
    logic [W2-1:0] q2, e2;
    logic [W3-1:0] q3, e3;
    logic e_str;
    wire m_rdy = rst_n && (!pend || age == D);
    wire m_fire = pend && age == D;
    wire m_xfer = in_valid && m_rdy;
    always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        pend <= 1'b0;
        age <= 0;
        e1 <= '0;
        e2 <= '0;
        e3 <= '0;
        e_str <= 1'b0;
      end else begin
        e_str <= m_fire;
        if (m_fire) begin
          e1 <= q1;
          e2 <= q2;
          e3 <= q3;
        end
        if (m_xfer) begin
          q1 <= pay1[W1-1:0];
          q2 <= pay2[W2-1:0];
          q3 <= pay3[W3-1:0];
          pend <= 1'b1;
          age <= 0;
        end else if (m_fire) pend <= 1'b0;
        else if (pend) age <= age + 1;
      end
    always @(posedge clk) begin
      #1;
      chk(k, "in_ready", 32'(bus.in_ready), 32'(m_rdy));
      chk(k, "busy", 32'(bus.busy), 32'(pend));
      chk(k, "d_strobe", 32'(bus.d_strobe), 32'(e_str));
      chk(k, "d1", 32'(bus.d1), 32'(e1));
      chk(k, "d2", 32'(bus.d2), 32'(e2));
      chk(k, "d3", 32'(bus.d3), 32'(e3));
    end
  end
  int c0, c1, c2;
  initial begin
    rst_n = 1'b0;
    in_valid = 1'b1;
    pay1 = 32'hFF;
    pay2 = 32'hFF;
    pay3 = 32'hFF;
    repeat (2) @(negedge clk);
    chk(0, "rst_rdy", 32'(g[0].bus.in_ready), 0);
    chk(2, "rst_rdy", 32'(g[2].bus.in_ready), 0);
    chk(0, "rst_d1", 32'(g[0].bus.d1), 0);
    chk(0, "rst_stb", 32'(g[0].bus.d_strobe), 0);
    chk(0, "rst_busy", 32'(g[0].bus.busy), 0);
    rst_n = 1'b1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    pay1 = 32'hA5;
    pay2 = 32'h2C;
    pay3 = 32'h13;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk(0, "lat_busy1", 32'(g[0].bus.busy), 1);
    @(negedge clk);
    chk(1, "lat0_d1", 32'(g[1].bus.d1), 32'hA5);
    repeat (4) @(negedge clk);
    chk(0, "lat_early_d1", 32'(g[0].bus.d1), 0);
    chk(0, "lat_busy6", 32'(g[0].bus.busy), 1);
    @(negedge clk);
    chk(0, "lat_d1", 32'(g[0].bus.d1), 32'hA5);
    chk(0, "lat_d2", 32'(g[0].bus.d2), 32'h2C);
    chk(0, "lat_d3", 32'(g[0].bus.d3), 32'h13);
    chk(0, "lat_stb", 32'(g[0].bus.d_strobe), 1);
    chk(0, "lat_busy_end", 32'(g[0].bus.busy), 0);
    @(negedge clk);
    chk(0, "lat_stb_off", 32'(g[0].bus.d_strobe), 0);
    chk(0, "lat_hold", 32'(g[0].bus.d1), 32'hA5);
    repeat (3) @(negedge clk);
    pay1 = '1;
    pay2 = '1;
    pay3 = '1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk(2, "ones_d1", 32'(g[2].bus.d1), 32'h7);
    chk(2, "ones_d2", 32'(g[2].bus.d2), 32'h3);
    chk(2, "ones_d3", 32'(g[2].bus.d3), 32'h3);
    chk(2, "ones_stb", 32'(g[2].bus.d_strobe), 1);
    repeat (8) @(negedge clk);
    for (int i = 1; i <= 6; i++) begin
      if (i >= 3) begin
        chk(1, "seq_d1", 32'(g[1].bus.d1), 32'(i - 2));
        chk(1, "seq_stb", 32'(g[1].bus.d_strobe), 1);
      end
      in_valid = i <= 4;
      pay1 = 32'(i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    in_valid = 1'b1;
    c0 = 0;
    c1 = 0;
    c2 = 0;
    for (int i = 0; i < 18; i++) begin
      c0 += int'(g[0].bus.in_ready);
      c1 += int'(g[1].bus.in_ready);
      c2 += int'(g[2].bus.in_ready);
      pay1 = $urandom;
      pay2 = $urandom;
      pay3 = $urandom;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk(0, "b2b_accepts", 32'(c0), 3);
    chk(1, "b2b_accepts", 32'(c1), 18);
    chk(2, "b2b_accepts", 32'(c2), 6);
    repeat (8) @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk(0, "mid_rst_d1", 32'(g[0].bus.d1), 0);
    chk(0, "mid_rst_busy", 32'(g[0].bus.busy), 0);
    chk(0, "mid_rst_rdy", 32'(g[0].bus.in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk(0, "post_rst_stb", 32'(g[0].bus.d_strobe), 0);
      chk(0, "post_rst_busy", 32'(g[0].bus.busy), 0);
    end
    pay1 = 32'h5A;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk(0, "post_rst_early", 32'(g[0].bus.d_strobe), 0);
    @(negedge clk);
    chk(0, "post_rst_stb1", 32'(g[0].bus.d_strobe), 1);
    chk(0, "post_rst_d1", 32'(g[0].bus.d1), 32'h5A);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      in_valid = $urandom_range(0, 3) != 0;
      pay1 = $urandom;
      pay2 = $urandom;
      pay3 = $urandom;
      rst_n = $urandom_range(0, 299) != 0;
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
